// File: rtl/cache_defs.sv
// Shared definitions for the cache miss handler: FSM encodings, default
// geometry and the block-alignment helper.
package cache_defs;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_WORDS  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WB   = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  // Number of low address bits cleared to reach a block base.
  function automatic int blk_lsb(input int data_w, input int words);
    return $clog2(data_w / 8) + $clog2(words);
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Miss-handler bus: tag-match request, data/tag array controls and the
// pipelined memory port. master = fill controller, slave = cache/memory side.
interface cache_fill_ctrl_if
  import cache_defs::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WORDS  = DEF_WORDS
);
  localparam int OFF_W = $clog2(WORDS);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              victim_dirty;
  logic [ADDR_W-1:0] victim_address;
  logic [DATA_W-1:0] array_rdata;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic [OFF_W-1:0]  array_word_sel;
  logic              write_data_array;
  logic              write_tag_array;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    input  miss_detected, miss_address, victim_dirty, victim_address,
    input  array_rdata, memory_data_valid,
    output fsm_busy, array_word_sel, write_data_array, write_tag_array,
    output mem_address, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    output miss_detected, miss_address, victim_dirty, victim_address,
    output array_rdata, memory_data_valid,
    input  fsm_busy, array_word_sel, write_data_array, write_tag_array,
    input  mem_address, mem_rd, mem_wr, mem_wdata
  );

endinterface

// File: rtl/fill_word_counter.sv
// Word counter for block transfers: one extra bit so the issue side can saturate
// at WORDS; terminal flag marks the enabled step on word WORDS-1.
module fill_word_counter #(
  parameter  int WORDS = 8,
  localparam int CNT_W = $clog2(WORDS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = en && (cnt_q == CNT_W'(WORDS - 1));

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss handler: optional dirty-victim writeback, then a pipelined block fill.
// One word per cycle each way; reads issue back to back, returns may be gapped.
module cache_fill_ctrl
  import cache_defs::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WORDS  = DEF_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  cache_fill_ctrl_if.master  bus
);

  localparam int BYTE_OFF = $clog2(DATA_W / 8);
  localparam int OFF_W    = $clog2(WORDS);
  localparam int CNT_W    = OFF_W + 1;
  localparam int BLK_LSB  = blk_lsb(DATA_W, WORDS);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << BLK_LSB) - ADDR_W'(1));

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] miss_base_q, miss_base_d;
  logic [ADDR_W-1:0] victim_base_q, victim_base_d;

  logic             iss_en, iss_clr, iss_term;
  logic             ret_en, ret_clr, ret_term;
  logic [CNT_W-1:0] iss_cnt, ret_cnt;

  logic              busy, rd, wr, wda, wta;
  logic [OFF_W-1:0]  sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] iss_off;

  assign iss_off = ADDR_W'(iss_cnt[OFF_W-1:0]) << BYTE_OFF;

  always_comb begin
    state_d       = state_q;
    miss_base_d   = miss_base_q;
    victim_base_d = victim_base_q;
    iss_en  = 1'b0;
    iss_clr = 1'b0;
    ret_en  = 1'b0;
    ret_clr = 1'b0;
    busy    = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    wda     = 1'b0;
    wta     = 1'b0;
    sel     = '0;
    addr    = '0;
    wdata   = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.miss_detected) begin
          miss_base_d   = bus.miss_address & BLK_MASK;
          victim_base_d = bus.victim_address & BLK_MASK;
          iss_clr       = 1'b1;
          ret_clr       = 1'b1;
          state_d       = bus.victim_dirty ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        busy   = 1'b1;
        wr     = 1'b1;
        sel    = iss_cnt[OFF_W-1:0];
        addr   = victim_base_q | iss_off;
        wdata  = bus.array_rdata;
        iss_en = 1'b1;
        if (iss_term) begin
          iss_clr = 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        busy = 1'b1;
        sel  = ret_cnt[OFF_W-1:0];
        // Issue side saturates at WORDS; the return side runs independently.
        if (!iss_cnt[OFF_W]) begin
          rd     = 1'b1;
          addr   = miss_base_q | iss_off;
          iss_en = 1'b1;
        end
        if (bus.memory_data_valid && !ret_cnt[OFF_W]) begin
          wda    = 1'b1;
          ret_en = 1'b1;
          if (ret_term) begin
            wta     = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      miss_base_q   <= '0;
      victim_base_q <= '0;
    end else begin
      state_q       <= state_d;
      miss_base_q   <= miss_base_d;
      victim_base_q <= victim_base_d;
    end
  end

  fill_word_counter #(.WORDS(WORDS)) u_iss (
    .clk (clk),
    .rst (rst),
    .en  (iss_en),
    .clr (iss_clr),
    .cnt (iss_cnt),
    .term(iss_term)
  );

  fill_word_counter #(.WORDS(WORDS)) u_ret (
    .clk (clk),
    .rst (rst),
    .en  (ret_en),
    .clr (ret_clr),
    .cnt (ret_cnt),
    .term(ret_term)
  );

  assign bus.fsm_busy         = busy;
  assign bus.array_word_sel   = sel;
  assign bus.write_data_array = wda;
  assign bus.write_tag_array  = wta;
  assign bus.mem_address      = addr;
  assign bus.mem_rd           = rd;
  assign bus.mem_wr           = wr;
  assign bus.mem_wdata        = wdata;

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Parametrised cache miss handler sitting between a cache's tag-match logic and the multicycle pipelined main memory. On a miss it writes a dirty victim block back to memory when required, then fills the missing block word by word. Memory read issue is decoupled from return counting, so all reads are pipelined back to back. It drives cache data/tag array write enables and a busy flag used by the pipeline stall logic.

## Interface
- ADDR_W, 16, byte-address width
- DATA_W, 16, memory/cache word width in bits; a multiple of 8, and DATA_W/8 a power of 2
- WORDS, 8, words per cache block; a power of 2, at least 2
- Derived: BYTE_OFF = log2(DATA_W/8), OFF_W = log2(WORDS), BLK_LSB = BYTE_OFF + OFF_W

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- miss_detected  in  1  tag-match logic reports a miss (sampled only in IDLE)
- miss_address  in  ADDR_W  missing byte address
- victim_dirty  in  1  the block being replaced is dirty
- victim_address  in  ADDR_W  any byte address within the victim block
- array_rdata  in  DATA_W  combinational data-array read of word array_word_sel
- memory_data_valid  in  1  read data is valid on the memory bus
- fsm_busy  out  1  miss in progress
- array_word_sel  out  OFF_W  word index into the cache block for array read/write
- write_data_array  out  1  write the memory return word into the data array
- write_tag_array  out  1  block complete; write tag and set valid, clear dirty
- mem_address  out  ADDR_W  memory word address
- mem_rd  out  1  issue a memory read
- mem_wr  out  1  issue a memory write
- mem_wdata  out  DATA_W  write data (equals array_rdata during WB)

## Operation
- States: IDLE, WB, FILL.
- IDLE: fsm_busy=0.
  - When miss_detected=1, latch miss_base = miss_address with the low BLK_LSB bits zeroed, and victim_base the same way.
  - Clear both counters. Go to WB if victim_dirty=1, otherwise FILL.
- WB:
  - Each cycle: mem_wr=1, array_word_sel=iss, mem_address = victim_base | (iss << BYTE_OFF), mem_wdata = array_rdata.
  - iss increments every cycle. After word WORDS-1, clear iss and go to FILL.
  - Memory accepts one write per cycle unconditionally.
- FILL, read issue:
  - While iss < WORDS: mem_rd=1, mem_address = miss_base | (iss << BYTE_OFF), iss increments.
  - iss saturates at WORDS, after which mem_rd=0.
- FILL, read return:
  - On memory_data_valid: write_data_array=1, array_word_sel=ret, ret increments.
  - On the valid carrying ret=WORDS-1: write_tag_array=1 in the same cycle, then go to IDLE.
- fsm_busy=1 in WB and FILL.
- memory_data_valid is ignored in IDLE and WB. miss_detected is ignored while busy.
- When neither mem_rd nor mem_wr is asserted: mem_address=0 and mem_wdata=0. array_word_sel=0 in IDLE.
- Combined stall = miss_detected | fsm_busy. Forming it is the top level's job.

## Timing
- Reset values: state IDLE, iss=ret=0, latched bases 0. All outputs 0.
- Reset applied mid-operation returns to IDLE the next cycle. In-flight returns then fall in IDLE and are ignored.
- Clean miss with memory latency L, miss at cycle 0:
  - FILL is entered at cycle 1; reads issue on cycles 1..WORDS.
  - Returns arrive on cycles 1+L..WORDS+L; write_tag_array fires on cycle WORDS+L.
  - fsm_busy is high on cycles 1..WORDS+L and low at WORDS+L+1.
- Dirty miss adds exactly WORDS cycles before the first read.
- Gapped or late returns are tolerated: FILL holds until WORDS valids have been counted.
- miss_detected in the cycle after write_tag_array starts a new miss normally.

## Structure
- Shared package cache_defs holds:
  - state encoding constants ST_IDLE, ST_WB, ST_FILL
  - default ADDR_W, DATA_W, WORDS
  - helper for block-base alignment width
- Sub-module fill_word_counter: OFF_W+1-bit up-counter with enable, synchronous clear, and terminal flag (count == WORDS-1 and enable). It is instantiated twice: iss (shared by WB and FILL issue) and ret.
- Top level holds the state register, the base latches, and the output muxing.

## Test plan
- Clean miss, defaults, L=4, miss_address=0xABCD -> mem_rd cycles 1-8 at 0xABC0,0xABC2..0xABCE; write_data_array cycles 5-12 with sel 0..7; write_tag_array only cycle 12; busy cycles 1-12.
- Dirty miss, victim_address=0x1235, miss 0xABCD -> mem_wr cycles 1-8 at 0x1230..0x123E with mem_wdata = array_rdata for sel 0..7; reads cycles 9-16; write_tag_array cycle 20.
- Returns every other cycle -> exactly 8 array writes; tag write on the 8th valid; busy held throughout; no extra mem_rd.
- memory_data_valid pulsed in IDLE and during WB, plus miss_detected with a new address mid-FILL -> no array writes, fill addresses unchanged.
- rst after 3 returns -> next cycle all outputs 0 and busy 0; a following miss at 0x0040 restarts at word 0 (first read 0x0040).
- WORDS=4, DATA_W=16, miss_address=0x0F05 -> reads at 0x0F00,0x0F02,0x0F04,0x0F06; tag write after 4 returns.
